// File: rtl/sender_crc16.sv
// Bit-serial CRC-16 encoder: emits {message, crc} as a one-cycle strobe MSG_W+1 clocks after accept.
// Backpressure only on input (in_ready low while busy); output has no backpressure and holds until next result.
module sender_crc16 #(
   parameter int               MSG_W    = 23,
   parameter int               CRC_W    = 16,
   parameter logic [CRC_W-1:0] POLY     = 16'h8005,
   parameter logic [CRC_W-1:0] CRC_INIT = 16'h0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [MSG_W-1:0]       message,
   output logic                   out_valid,
   output logic [MSG_W+CRC_W-1:0] encoded_message
);

   localparam int CNT_W = $clog2(MSG_W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [MSG_W-1:0]   r_msg;
   logic [MSG_W-1:0]   r_shift;
   logic [CRC_W-1:0]   r_crc;
   logic [CRC_W-1:0]   w_crc_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_fb;
   logic               w_last_bit;

   assign in_ready   = (r_state == IDLE);
   assign w_last_bit = (r_cnt == CNT_W'(MSG_W - 1));

   // Non-reflected LFSR step: feedback is the outgoing message bit against the CRC MSB.
   assign w_fb      = r_shift[MSG_W-1] ^ r_crc[CRC_W-1];
   assign w_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_next_state = SHIFT;
         SHIFT:   if (w_last_bit) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_msg           <= '0;
         r_shift         <= '0;
         r_crc           <= CRC_INIT;
         r_cnt           <= '0;
         out_valid       <= 1'b0;
         encoded_message <= '0;
      end else begin
         out_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_msg   <= message;
                  r_shift <= message;
                  r_crc   <= CRC_INIT;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_crc   <= w_crc_nxt;
               r_shift <= {r_shift[MSG_W-2:0], 1'b0};
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            DONE: begin
               encoded_message <= {r_msg, r_crc};
               out_valid       <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sender_crc16.sv
// Bench for sender_crc16: long-division reference model compared every cycle,
// plus directed literal codewords, in-flight input changes and mid-shift reset.
module tb_sender_crc16;

   localparam int MSG_W = 23;
   localparam int CRC_W = 16;
   localparam int ENC_W = MSG_W + CRC_W;

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [MSG_W-1:0] message  = '0;
   logic             out_valid;
   logic [ENC_W-1:0] encoded_message;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   sender_crc16 dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .message         (message),
      .out_valid       (out_valid),
      .encoded_message (encoded_message)
   );

   // Remainder of message*x^16 divided by x^16+x^15+x^2+1 (0x18005), GF(2) long division.
   function automatic logic [CRC_W-1:0] ref_crc(input logic [MSG_W-1:0] m);
      logic [ENC_W-1:0] r;
      r = {m, 16'h0000};
      for (int i = ENC_W - 1; i >= CRC_W; i--) begin
         if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h18005;
      end
      return r[CRC_W-1:0];
   endfunction

   task automatic check(input string name, input logic [ENC_W-1:0] got, input logic [ENC_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: one word in flight; accept when idle, result due 24 edges later,
   // ready again on the edge the result appears.
   int               cyc       = 0;
   int               m_next_ok = 0;
   int               m_due     = -1;
   bit               m_pend    = 1'b0;
   bit               m_strobe  = 1'b0;
   logic [ENC_W-1:0] m_word    = '0;
   logic [ENC_W-1:0] m_last    = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend    = 1'b0;
         m_strobe  = 1'b0;
         m_last    = '0;
         m_next_ok = 0;
      end else begin
         cyc++;
         m_strobe = 1'b0;
         if (m_pend && cyc == m_due) begin
            m_strobe = 1'b1;
            m_last   = m_word;
            m_pend   = 1'b0;
         end
         if (in_valid && cyc >= m_next_ok) begin
            m_word    = {message, ref_crc(message)};
            m_due     = cyc + MSG_W + 1;
            m_next_ok = cyc + MSG_W + 2;
            m_pend    = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", {38'b0, out_valid}, {38'b0, m_strobe});
         check("in_ready", {38'b0, in_ready}, {38'b0, (cyc >= m_next_ok - 1)});
         check("encoded_message", encoded_message, m_last);
      end
   end

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic send(input logic [MSG_W-1:0] m, input bit drop_valid);
      int n;
      message  = m;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 100) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      end
      @(posedge clk); #2;
      if (drop_valid) in_valid = 1'b0;
   endtask

   task automatic wait_strobe(output logic [ENC_W-1:0] word, output int lat);
      lat  = 0;
      word = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat  = k;
            word = encoded_message;
            break;
         end
      end
      if (lat == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL strobe_timeout: out_valid=0 for 40 clocks, required a strobe");
      end
      #1;
   endtask

   logic [MSG_W-1:0] dir_msg [4] = '{23'h000001, 23'h000002, 23'h000003, 23'h000000};
   logic [CRC_W-1:0] dir_crc [4] = '{16'h8005,   16'h800F,   16'h000A,   16'h0000};
   logic [MSG_W-1:0] b2b_msg [5] = '{23'h654321, 23'h7FFFFF, 23'h555555, 23'h078795, 23'h421111};

   initial begin
      logic [ENC_W-1:0] w;
      int               lat;
      int               strobes;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk_en = 1'b1;
      check("reset_in_ready", {38'b0, in_ready}, 39'd1);
      check("reset_out_valid", {38'b0, out_valid}, 39'd0);
      check("reset_encoded", encoded_message, 39'd0);

      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      check("idle_out_valid", {38'b0, out_valid}, 39'd0);

      for (int i = 0; i < 4; i++) begin
         send(dir_msg[i], 1'b1);
         wait_strobe(w, lat);
         check("latency", 39'(lat), 39'd24);
         check("directed_codeword", w, {dir_msg[i], dir_crc[i]});
      end

      // Back-to-back with in_valid held; the per-cycle compare checks each result.
      for (int i = 0; i < 5; i++) send(b2b_msg[i], 1'b0);
      in_valid = 1'b0;
      repeat (30) @(posedge clk);
      #2;

      // Inputs wiggled while shifting must not disturb the latched word.
      send(23'h2AAAAA, 1'b1);
      for (int i = 0; i < 10; i++) begin
         message  = MSG_W'($urandom);
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #2;
      end
      in_valid = 1'b0;
      wait_strobe(w, lat);
      check("shift_ignore_inputs", w, {23'h2AAAAA, 16'h2A0B ^ 16'h0000} ^ {23'h0, 16'h2A0B ^ ref_crc(23'h2AAAAA)});

      // Reset ten cycles into SHIFT aborts the word.
      send(23'h7FFFFF, 1'b1);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", {38'b0, in_ready}, 39'd1);
      check("abort_encoded", encoded_message, 39'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      strobes = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) strobes++;
      end
      #1;
      check("abort_no_strobe", 39'(strobes), 39'd0);

      send(23'h000003, 1'b1);
      wait_strobe(w, lat);
      check("post_reset_latency", 39'(lat), 39'd24);
      check("post_reset_codeword", w, {23'h000003, 16'h000A});

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
